// File: rtl/y86_fetch.sv
// Y86-64 pipeline fetch stage: PC select, instruction split/validation,
// next-PC prediction, and the RUN/HOLD stall FSM that owns F_predPC.
module y86_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [63:0] imem_addr,
  input  logic [79:0] imem_data,
  input  logic        imem_error,
  output logic [63:0] f_pc,
  output logic [1:0]  f_stat,
  output logic [7:0]  f_opcode,
  output logic [7:0]  f_rArB,
  output logic [63:0] f_valC,
  output logic [63:0] f_valP
);

  typedef enum logic {RUN, HOLD} state_e;
  typedef enum logic [1:0] {STAT_AOK = 2'b00, STAT_HLT = 2'b01,
                            STAT_ADR = 2'b10, STAT_INS = 2'b11} stat_e;

  localparam logic [63:0] MEM_LIMIT = 64'(IMEM_SIZE);

  state_e      state_q, state_d;
  logic [63:0] pred_pc_q, pred_pc_d;

  logic        mispredict, ret_w, redirect;
  logic [63:0] pc;
  logic [3:0]  icode, ifun;
  logic        need_regids, need_valc, instr_valid, adr_fault;
  logic [3:0]  ilen;
  logic [63:0] valc, valp, pred_pc;
  stat_e       stat;

  assign mispredict = (M_icode == 4'h7) && !M_Cnd;
  assign ret_w      = (W_icode == 4'h9);
  assign redirect   = mispredict || ret_w;

  always_comb begin
    pc = pred_pc_q;
    if (mispredict)
      pc = M_valA;
    else if (ret_w)
      pc = W_valM;
  end

  assign imem_addr = pc;
  assign icode     = imem_data[7:4];
  assign ifun      = imem_data[3:0];

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      4'h7, 4'h8: need_valc = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (icode)
      4'h2, 4'h7:                          instr_valid = (ifun <= 4'd6);
      4'h6:                                instr_valid = (ifun <= 4'd3);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8,
      4'h9, 4'hA, 4'hB:                    instr_valid = (ifun == 4'd0);
      default:                             instr_valid = 1'b0;
    endcase
  end

  assign ilen = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
  assign valc = need_valc ? (need_regids ? imem_data[79:16] : imem_data[71:8]) : '0;
  assign valp = pc + {60'd0, ilen};

  // Last byte pc+len-1 >= limit, rewritten as len > limit-pc so nothing overflows.
  assign adr_fault = imem_error || (pc >= MEM_LIMIT) ||
                     ({60'd0, ilen} > (MEM_LIMIT - pc));

  always_comb begin
    if (adr_fault)
      stat = STAT_ADR;
    else if (!instr_valid)
      stat = STAT_INS;
    else if (icode == 4'h0)
      stat = STAT_HLT;
    else
      stat = STAT_AOK;
  end

  assign pred_pc = (icode == 4'h7 || icode == 4'h8) ? valc : valp;

  always_comb begin
    f_pc     = pc;
    f_stat   = stat;
    f_opcode = imem_data[7:0];
    f_rArB   = need_regids ? imem_data[15:8] : 8'hFF;
    f_valC   = valc;
    f_valP   = valp;
    if (stat == STAT_ADR) begin
      f_opcode = 8'h10;
      f_rArB   = 8'hFF;
      f_valC   = '0;
      f_valP   = pc;
    end
  end

  // HOLD parks on the faulting PC until a redirect supplies a new one.
  always_comb begin
    pred_pc_d = pred_pc_q;
    state_d   = state_q;
    if (!F_stall && (state_q == RUN || redirect)) begin
      pred_pc_d = (stat == STAT_AOK) ? pred_pc : pc;
      state_d   = (stat == STAT_AOK) ? RUN : HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_pc_q <= RESET_PC;
      state_q   <= RUN;
    end else begin
      pred_pc_q <= pred_pc_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_y86_fetch.sv
// Directed bench for y86_fetch: a byte-array instruction memory, a stimulus
// process queuing hand-computed expectations, and a negedge scoreboard monitor.
module tb_y86_fetch;

  logic        clk = 1'b0;
  logic        rst, F_stall, M_Cnd, imem_error;
  logic [3:0]  M_icode, W_icode;
  logic [63:0] M_valA, W_valM, imem_addr, f_pc, f_valC, f_valP;
  logic [79:0] imem_data;
  logic [1:0]  f_stat;
  logic [7:0]  f_opcode, f_rArB;

  always #5 clk = ~clk;

  y86_fetch #(.RESET_PC(64'h0), .IMEM_SIZE(1024)) dut (
    .clk(clk), .rst(rst), .F_stall(F_stall),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_error(imem_error),
    .f_pc(f_pc), .f_stat(f_stat), .f_opcode(f_opcode), .f_rArB(f_rArB),
    .f_valC(f_valC), .f_valP(f_valP)
  );

  logic [7:0] mem [0:1023];

  always_comb begin
    logic [63:0] a;
    imem_data = '0;
    for (int i = 0; i < 10; i++) begin
      a = imem_addr + 64'(i);
      if (a < 64'd1024) imem_data[i*8 +: 8] = mem[a[9:0]];
    end
  end

  typedef struct {
    logic [63:0] tag;
    logic [63:0] pc;
    logic [1:0]  st;
    logic [7:0]  op;
    logic [7:0]  rab;
    logic [63:0] vc;
    logic [63:0] vp;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_cmp++;
      if (f_pc !== mon_e.pc || imem_addr !== mon_e.pc || f_stat !== mon_e.st ||
          f_opcode !== mon_e.op || f_rArB !== mon_e.rab ||
          f_valC !== mon_e.vc || f_valP !== mon_e.vp) begin
        n_bad++;
        $display("FAIL %s: got pc=%h addr=%h st=%b op=%h rAB=%h valC=%h valP=%h | want pc=%h st=%b op=%h rAB=%h valC=%h valP=%h",
                 mon_e.tag, f_pc, imem_addr, f_stat, f_opcode, f_rArB, f_valC, f_valP,
                 mon_e.pc, mon_e.st, mon_e.op, mon_e.rab, mon_e.vc, mon_e.vp);
      end
    end
  end

  task automatic expect_out(input logic [63:0] tag, input logic [63:0] pc,
                            input logic [1:0] st, input logic [7:0] op,
                            input logic [7:0] rab, input logic [63:0] vc,
                            input logic [63:0] vp);
    exp_t e;
    e.tag = tag; e.pc = pc; e.st = st; e.op = op; e.rab = rab; e.vc = vc; e.vp = vp;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] mi, input logic mc, input logic [63:0] mva,
                     input logic [3:0] wi, input logic [63:0] wvm);
    M_icode = mi; M_Cnd = mc; M_valA = mva; W_icode = wi; W_valM = wvm;
  endtask

  task automatic put64(input int addr, input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem[addr + i] = v[i*8 +: 8];
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h000] = 8'h30; mem[10'h001] = 8'hF2; put64(10'h002, 64'h0A);   // irmovq $10,%rdx
    mem[10'h00A] = 8'h10;                                                  // nop
    mem[10'h00B] = 8'h20; mem[10'h00C] = 8'h12;                            // rrmovq
    mem[10'h020] = 8'h70; put64(10'h021, 64'h100);                         // jmp 0x100
    mem[10'h100] = 8'h10; mem[10'h101] = 8'h10;
    mem[10'h029] = 8'h60; mem[10'h02A] = 8'h23;                            // addq
    mem[10'h02B] = 8'h10;
    mem[10'h040] = 8'h80; put64(10'h041, 64'h70);                          // call 0x70
    mem[10'h050] = 8'h10;
    mem[10'h051] = 8'h30; mem[10'h052] = 8'hF3; put64(10'h053, 64'h1122334455667788);
    mem[10'h05B] = 8'h61; mem[10'h05C] = 8'h45;                            // subq
    mem[10'h05D] = 8'h10;
    mem[10'h060] = 8'h10;
    mem[10'h061] = 8'hF0;                                                  // bad icode
    mem[10'h070] = 8'h65; mem[10'h071] = 8'h12;                            // bad ifun for OPq
    mem[10'h080] = 8'h26; mem[10'h081] = 8'h34;                            // cmovg, valid
    mem[10'h082] = 8'h27;                                                  // ifun 7, invalid
    // irmovq ending exactly at 0x3FF; its constant overlaps the irmovq at 0x3FC
    mem[10'h3F6] = 8'h30; mem[10'h3F7] = 8'hF4; put64(10'h3F8, 64'h0000F230_00000001);

    rst = 1'b1; F_stall = 1'b0; imem_error = 1'b0;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    tick;
    rst = 1'b0;

    expect_out("reset", 64'h0, 2'b00, 8'h30, 8'hF2, 64'hA, 64'hA); tick;
    expect_out("nop", 64'hA, 2'b00, 8'h10, 8'hFF, 64'h0, 64'hB); tick;
    expect_out("rrmovq", 64'hB, 2'b00, 8'h20, 8'h12, 64'h0, 64'hD); tick;
    drv(4'h7, 1'b0, 64'h20, 4'h0, '0);
    expect_out("jxx", 64'h20, 2'b00, 8'h70, 8'hFF, 64'h100, 64'h29); tick;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    expect_out("jtarget", 64'h100, 2'b00, 8'h10, 8'hFF, 64'h0, 64'h101); tick;
    expect_out("jtarg+1", 64'h101, 2'b00, 8'h10, 8'hFF, 64'h0, 64'h102); tick;
    drv(4'h7, 1'b0, 64'h29, 4'h0, '0);
    expect_out("mispred", 64'h29, 2'b00, 8'h60, 8'h23, 64'h0, 64'h2B); tick;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    expect_out("postmisp", 64'h2B, 2'b00, 8'h10, 8'hFF, 64'h0, 64'h2C); tick;
    drv(4'h0, 1'b0, '0, 4'h9, 64'h40);
    expect_out("ret", 64'h40, 2'b00, 8'h80, 8'hFF, 64'h70, 64'h49); tick;
    drv(4'h7, 1'b0, 64'h50, 4'h9, 64'h40);
    expect_out("misp>ret", 64'h50, 2'b00, 8'h10, 8'hFF, 64'h0, 64'h51); tick;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    expect_out("valC_le", 64'h51, 2'b00, 8'h30, 8'hF3, 64'h1122334455667788, 64'h5B); tick;
    F_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out("stall", 64'h5B, 2'b00, 8'h61, 8'h45, 64'h0, 64'h5D); tick;
    end
    F_stall = 1'b0;
    expect_out("unstall", 64'h5B, 2'b00, 8'h61, 8'h45, 64'h0, 64'h5D); tick;
    drv(4'h7, 1'b1, 64'h99, 4'h0, '0);
    expect_out("taken", 64'h5D, 2'b00, 8'h10, 8'hFF, 64'h0, 64'h5E); tick;
    drv(4'h7, 1'b0, 64'h30, 4'h0, '0);
    expect_out("halt", 64'h30, 2'b01, 8'h00, 8'hFF, 64'h0, 64'h31); tick;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    for (int i = 0; i < 5; i++) begin
      expect_out("haltHOLD", 64'h30, 2'b01, 8'h00, 8'hFF, 64'h0, 64'h31); tick;
    end
    drv(4'h7, 1'b0, 64'h60, 4'h0, '0);
    expect_out("resume", 64'h60, 2'b00, 8'h10, 8'hFF, 64'h0, 64'h61); tick;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    expect_out("insF0", 64'h61, 2'b11, 8'hF0, 8'hFF, 64'h0, 64'h62); tick;
    expect_out("insHOLD", 64'h61, 2'b11, 8'hF0, 8'hFF, 64'h0, 64'h62); tick;
    drv(4'h7, 1'b0, 64'h70, 4'h0, '0);
    expect_out("ins65", 64'h70, 2'b11, 8'h65, 8'h12, 64'h0, 64'h72); tick;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    expect_out("ins65hld", 64'h70, 2'b11, 8'h65, 8'h12, 64'h0, 64'h72); tick;
    rst = 1'b1; tick;
    rst = 1'b0;
    expect_out("rst_hold", 64'h0, 2'b00, 8'h30, 8'hF2, 64'hA, 64'hA); tick;
    drv(4'h7, 1'b0, 64'h3FC, 4'h0, '0);
    expect_out("adr3FC", 64'h3FC, 2'b10, 8'h10, 8'hFF, 64'h0, 64'h3FC); tick;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    expect_out("adrHOLD", 64'h3FC, 2'b10, 8'h10, 8'hFF, 64'h0, 64'h3FC); tick;
    drv(4'h7, 1'b0, 64'h3F6, 4'h0, '0);
    expect_out("fitedge", 64'h3F6, 2'b00, 8'h30, 8'hF4, 64'h0000F230_00000001, 64'h400); tick;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    expect_out("adr400", 64'h400, 2'b10, 8'h10, 8'hFF, 64'h0, 64'h400); tick;
    drv(4'h7, 1'b0, 64'h0, 4'h0, '0);
    imem_error = 1'b1;
    expect_out("imemerr", 64'h0, 2'b10, 8'h10, 8'hFF, 64'h0, 64'h0); tick;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    imem_error = 1'b0;
    expect_out("holdok1", 64'h0, 2'b00, 8'h30, 8'hF2, 64'hA, 64'hA); tick;
    expect_out("holdok2", 64'h0, 2'b00, 8'h30, 8'hF2, 64'hA, 64'hA); tick;
    drv(4'h7, 1'b0, 64'h80, 4'h0, '0);
    expect_out("cmov26", 64'h80, 2'b00, 8'h26, 8'h34, 64'h0, 64'h82); tick;
    drv(4'h0, 1'b0, '0, 4'h0, '0);
    expect_out("ins27", 64'h82, 2'b11, 8'h27, 8'h00, 64'h0, 64'h84); tick;

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
